// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the TRNG byte reader:
//   - trng_state_e : control FSM states (warm-up, running, health failure)
//   - DEF_*        : default parameter values for the reader and its FIFO
//   - level_w()    : width of a FIFO occupancy count able to hold 0..depth
//   - cnt_w()      : width of a counter able to hold 0..max_val
// -----------------------------------------------------------------------------
package trng_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAIL   = 2'd2
    } trng_state_e;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_WARMUP     = 64;
    localparam int DEF_RCT_CUTOFF = 32;

    // Occupancy must represent both 0 and DEPTH, hence one bit more than
    // the pointer width.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_byte_fifo.sv
// -----------------------------------------------------------------------------
// trng_byte_fifo
// Synchronous byte FIFO with push, pop, flush and an occupancy count.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write push_data_i (dropped if full and not popping)
//   push_data_i   : byte to write
//   pop_i         : remove the head entry (ignored when empty)
//   flush_i       : empty the FIFO; overrides push and pop
//   head_o        : current head byte, 0 when empty
//   empty_o       : no entries held
//   drop_o        : a push was discarded this cycle because the FIFO was full
//   level_o       : number of entries held (0..DEPTH)
// A push and a pop in the same cycle both succeed even when full, so the
// FIFO can stream at one byte per cycle at full occupancy.
// -----------------------------------------------------------------------------
module trng_byte_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [7:0]                push_data_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    output logic [7:0]                head_o,
    output logic                      empty_o,
    output logic                      drop_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic full;
    logic do_push;
    logic do_pop;

    assign empty_o = (level_q == '0);
    assign full    = (level_q == FULL_LVL);

    // A pop frees a slot in the same cycle, so a push at full occupancy is
    // accepted whenever it is paired with a pop.
    assign do_pop  = pop_i  && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);
    assign drop_o  = push_i && !flush_i && full && !do_pop;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and level do. Stale
    // entries are never visible because head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/trng_byte_reader.sv
// -----------------------------------------------------------------------------
// trng_byte_reader
// Consumer end of the TRNG raw-bit stream. Discards a warm-up window of raw
// samples, von Neumann debiases the rest, packs surviving bits MSB-first into
// bytes, buffers them in a small FIFO and presents them on a valid/ready
// interface. A repetition-count test (RCT) watches the raw stream and latches
// a sticky failure that shuts the block down until reset.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : block enable; low restarts warm-up (ignored after failure)
//   raw_bit     : raw entropy sample
//   raw_valid   : raw_bit qualifier, at most one sample per cycle
//   byte_data   : FIFO head byte
//   byte_valid  : FIFO non-empty and health test not failed
//   byte_ready  : consumer accepts byte_data
//   fifo_level  : bytes held in the FIFO
//   overflow    : sticky, a finished byte was dropped because the FIFO was full
//   health_fail : sticky, the repetition-count test tripped
// -----------------------------------------------------------------------------
module trng_byte_reader
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WARMUP     = DEF_WARMUP,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           raw_bit,
    input  logic                           raw_valid,
    output logic [7:0]                     byte_data,
    output logic                           byte_valid,
    input  logic                           byte_ready,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           overflow,
    output logic                           health_fail
);

    localparam int WARM_W = cnt_w(WARMUP);
    localparam int RCT_W  = cnt_w(RCT_CUTOFF);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [RCT_W-1:0]  RCT_TRIP  = RCT_W'(RCT_CUTOFF);

    // Control and datapath state
    trng_state_e       state_q,     state_d;
    logic [WARM_W-1:0] warm_cnt_q,  warm_cnt_d;   // warm-up samples seen
    logic              pair_full_q, pair_full_d;  // first half of pair held
    logic              pair_bit_q,  pair_bit_d;   // first half of pair
    logic [6:0]        pack_q,      pack_d;       // up to 7 debiased bits
    logic [2:0]        bit_cnt_q,   bit_cnt_d;    // bits held in pack_q
    logic [RCT_W-1:0]  rct_cnt_q,   rct_cnt_d;    // current run length, 0 = none yet
    logic              rct_prev_q,  rct_prev_d;   // previous raw sample
    logic              overflow_q;

    // FIFO interface
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_drop;
    logic [7:0] fifo_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= '0;
            pair_full_q <= 1'b0;
            pair_bit_q  <= 1'b0;
            pack_q      <= '0;
            bit_cnt_q   <= '0;
            rct_cnt_q   <= '0;
            rct_prev_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            pair_full_q <= pair_full_d;
            pair_bit_q  <= pair_bit_d;
            pack_q      <= pack_d;
            bit_cnt_q   <= bit_cnt_d;
            rct_cnt_q   <= rct_cnt_d;
            rct_prev_q  <= rct_prev_d;
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        pair_full_d = pair_full_q;
        pair_bit_d  = pair_bit_q;
        pack_d      = pack_q;
        bit_cnt_d   = bit_cnt_q;
        rct_cnt_d   = rct_cnt_q;
        rct_prev_d  = rct_prev_q;
        push        = 1'b0;
        flush       = 1'b0;
        // The byte completed by the current pair: 7 held bits plus the
        // first half of the pair, which is the emitted bit for a "10"/"01".
        push_data   = {pack_q, pair_bit_q};

        if (state_q != ST_FAIL && !en) begin
            // Disabling abandons all in-flight entropy; only the FIFO survives.
            state_d     = ST_WARMUP;
            warm_cnt_d  = '0;
            pair_full_d = 1'b0;
            pair_bit_d  = 1'b0;
            pack_d      = '0;
            bit_cnt_d   = '0;
            rct_cnt_d   = '0;
            rct_prev_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_WARMUP: begin
                    if (raw_valid) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            warm_cnt_d = '0;
                            state_d    = ST_RUN;
                        end else begin
                            warm_cnt_d = warm_cnt_q + WARM_W'(1);
                        end
                    end
                end

                ST_RUN: begin
                    if (raw_valid) begin
                        // Repetition count: a zero count marks the first
                        // sample after warm-up, which always starts a run.
                        rct_prev_d = raw_bit;
                        if (rct_cnt_q == '0 || raw_bit != rct_prev_q) begin
                            rct_cnt_d = RCT_W'(1);
                        end else begin
                            rct_cnt_d = rct_cnt_q + RCT_W'(1);
                        end

                        if (rct_cnt_d == RCT_TRIP) begin
                            // The tripping sample is not trusted for output;
                            // flushing now means the FIFO is already empty
                            // when health_fail becomes visible.
                            state_d = ST_FAIL;
                            flush   = 1'b1;
                        end else if (!pair_full_q) begin
                            pair_full_d = 1'b1;
                            pair_bit_d  = raw_bit;
                        end else begin
                            pair_full_d = 1'b0;
                            pair_bit_d  = 1'b0;
                            // Unequal pair emits its first bit; equal pairs
                            // are discarded.
                            if (pair_bit_q != raw_bit) begin
                                pack_d = {pack_q[5:0], pair_bit_q};
                                if (bit_cnt_q == 3'd7) begin
                                    push      = 1'b1;
                                    bit_cnt_d = 3'd0;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 3'd1;
                                end
                            end
                        end
                    end
                end

                ST_FAIL: begin
                    flush = 1'b1;
                end

                default: begin
                    state_d = ST_WARMUP;
                end
            endcase
        end
    end

    assign byte_valid = !fifo_empty && (state_q != ST_FAIL);
    assign pop        = byte_valid && byte_ready;

    trng_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop),
        .level_o     (fifo_level)
    );

    assign byte_data   = fifo_head;
    assign overflow    = overflow_q;
    assign health_fail = (state_q == ST_FAIL);

endmodule

// File: tb/tb_trng_byte_reader.sv
// -----------------------------------------------------------------------------
// tb_trng_byte_reader
// Directed scenarios followed by a randomized phase checked cycle by cycle
// against a queue-based reference model of warm-up, debiasing, packing and
// the byte FIFO.
// -----------------------------------------------------------------------------
module tb_trng_byte_reader;

    localparam int DEPTH  = 4;
    localparam int WARM   = 64;
    localparam int RND_N  = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       raw_bit;
    logic       raw_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       health_fail;

    int checks = 0;
    int errors = 0;

    // Monitor: every accepted byte and every cycle with byte_valid high.
    logic [7:0] got[$];
    int         valid_cycles = 0;

    // Reference model state for the randomized phase
    int         m_warm;
    logic       m_pair[$];
    logic       m_bits[$];
    logic [7:0] m_fifo[$];
    logic       m_ovf;

    trng_byte_reader #(
        .FIFO_DEPTH (DEPTH),
        .WARMUP     (WARM),
        .RCT_CUTOFF (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) valid_cycles++;
        if (byte_valid && byte_ready) got.push_back(byte_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    task automatic send_pair(input logic a, input logic b);
        send(a);
        send(b);
    endtask

    // Eight pairs that debias to v, MSB first.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) send_pair(1'b1, 1'b0);
            else      send_pair(1'b0, 1'b1);
        end
    endtask

    task automatic warmup_rand(input int n);
        repeat (n) send(1'($urandom));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " byte_valid"},  byte_valid,  1'b0);
        check({tag, " fifo_level"},  fifo_level,  3'd0);
        check({tag, " overflow"},    overflow,    1'b0);
        check({tag, " health_fail"}, health_fail, 1'b0);
        check({tag, " byte_data"},   byte_data,   8'h00);
    endtask

    initial begin
        int base;
        int vbase;
        int run_len;
        logic last_bit;
        logic b;
        logic pop_m;
        logic new_m;
        logic [7:0] byte_m;

        rst        = 1'b1;
        en         = 1'b0;
        raw_bit    = 1'b0;
        raw_valid  = 1'b0;
        byte_ready = 1'b0;

        // ---------------- reset state
        repeat (2) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // ---------------- basic byte 0xB2
        en         = 1'b1;
        byte_ready = 1'b1;
        warmup_rand(WARM);
        base  = got.size();
        vbase = valid_cycles;
        send_byte(8'hB2);
        check("basic valid after 8th pair", byte_valid, 1'b1);
        check("basic head",                 byte_data,  8'hB2);
        check("basic level",                fifo_level, 3'd1);
        repeat (2) tick();
        check("basic level drained", fifo_level, 3'd0);
        check("basic byte count",    got.size() - base, 1);
        check("basic byte",          got_at(base), 8'hB2);
        check("basic valid cycles",  valid_cycles - vbase, 1);

        // ---------------- discard equal pairs
        base = got.size();
        send_pair(0, 0); send_pair(1, 0); send_pair(1, 1); send_pair(1, 0);
        send_pair(0, 0); send_pair(1, 0); send_pair(1, 1); send_pair(1, 0);
        send_pair(1, 0); send_pair(1, 0); send_pair(1, 0); send_pair(1, 0);
        repeat (2) tick();
        check("discard byte count", got.size() - base, 1);
        check("discard byte FF",    got_at(base), 8'hFF);
        base = got.size();
        send_byte(8'h00);
        repeat (2) tick();
        check("zero byte count", got.size() - base, 1);
        check("zero byte 00",    got_at(base), 8'h00);

        // ---------------- overflow and backpressure
        byte_ready = 1'b0;
        base = got.size();
        for (int k = 1; k <= 5; k++) begin
            send_byte(8'(k));
            check("ovf level", fifo_level, (k < DEPTH) ? k : DEPTH);
            check("ovf flag",  overflow,   (k > DEPTH) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall head",  byte_data,  8'h01);
            check("stall valid", byte_valid, 1'b1);
        end
        // Byte 0x06 completes on the same edge as a pop while full.
        for (int i = 7; i >= 1; i--) begin
            if (i == 1 || i == 2) send_pair(1'b1, 1'b0);
            else                  send_pair(1'b0, 1'b1);
        end
        send(1'b0);
        byte_ready = 1'b1;
        send(1'b1);
        byte_ready = 1'b0;
        check("full push+pop level", fifo_level, 3'd4);
        check("full push+pop head",  byte_data,  8'h02);
        byte_ready = 1'b1;
        repeat (6) tick();
        check("drain count", got.size() - base, 5);
        check("drain 0",     got_at(base),     8'h01);
        check("drain 1",     got_at(base + 1), 8'h02);
        check("drain 2",     got_at(base + 2), 8'h03);
        check("drain 3",     got_at(base + 3), 8'h04);
        check("drain 4",     got_at(base + 4), 8'h06);
        check("drain level", fifo_level, 3'd0);

        // ---------------- health test
        byte_ready = 1'b0;
        send_byte(8'hB2);
        check("health pre level", fifo_level, 3'd1);
        send_pair(1'b0, 1'b0);
        repeat (31) send(1'b1);
        send(1'b0);
        check("rct 31 no trip", health_fail, 1'b0);
        check("rct 31 level",   fifo_level,  3'd1);
        repeat (31) send(1'b1);
        check("rct 31b no trip", health_fail, 1'b0);
        send(1'b1);
        check("rct 32 trip",      health_fail, 1'b1);
        check("rct flush level",  fifo_level,  3'd0);
        check("rct valid forced", byte_valid,  1'b0);
        base = got.size();
        byte_ready = 1'b1;
        repeat (8) send_pair(1'b1, 1'b0);
        check("fail no bytes",    got.size() - base, 0);
        check("fail level",       fifo_level, 3'd0);
        en = 1'b0;
        tick();
        check("fail ignores en",  health_fail, 1'b1);
        en = 1'b1;
        rst = 1'b1;
        #1;
        check_idle("rst after fail");
        tick();
        rst = 1'b0;

        // ---------------- en toggle
        byte_ready = 1'b0;
        warmup_rand(WARM);
        send_byte(8'h5A);
        check("en buffered level", fifo_level, 3'd1);
        repeat (3) send_pair(1'b1, 1'b0);
        en         = 1'b0;
        byte_ready = 1'b1;
        #1;
        check("en low valid", byte_valid, 1'b1);
        check("en low head",  byte_data,  8'h5A);
        base = got.size();
        tick();
        check("en low drained", fifo_level, 3'd0);
        check("en low read",    got_at(base), 8'h5A);
        en = 1'b1;
        // 63 zeros then a 1 fill a fresh warm-up window exactly.
        repeat (WARM - 1) send(1'b0);
        send(1'b1);
        base = got.size();
        send_byte(8'hC3);
        repeat (2) tick();
        check("re-warm count", got.size() - base, 1);
        check("re-warm byte",  got_at(base), 8'hC3);

        // ---------------- reset mid-operation
        byte_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        byte_ready = 1'b1;
        repeat (2) tick();
        byte_ready = 1'b0;
        check("mid level 2",  fifo_level, 3'd2);
        check("mid overflow", overflow,   1'b1);
        rst = 1'b1;
        #1;
        check_idle("rst mid-op");
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        warmup_rand(WARM);
        base = got.size();
        send_byte(8'h3C);
        repeat (2) tick();
        check("post-rst byte", got_at(base), 8'h3C);

        // ---------------- randomized phase against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b1;
        m_warm = WARM;
        m_pair.delete();
        m_bits.delete();
        m_fifo.delete();
        m_ovf    = 1'b0;
        run_len  = 0;
        last_bit = 1'b0;
        for (int c = 0; c < RND_N; c++) begin
            byte_ready = ($urandom_range(0, 9) < 7);
            raw_valid  = ($urandom_range(0, 3) != 0);
            b = 1'($urandom);
            // Keep raw runs well below the cutoff so the stream stays healthy.
            if (run_len >= 16 && b == last_bit) b = ~b;
            raw_bit = b;

            check("rnd level",  fifo_level, m_fifo.size());
            check("rnd valid",  byte_valid, (m_fifo.size() > 0) ? 1 : 0);
            if (m_fifo.size() > 0) check("rnd head", byte_data, m_fifo[0]);
            check("rnd overflow", overflow,    m_ovf);
            check("rnd health",   health_fail, 1'b0);

            pop_m = (m_fifo.size() > 0) && byte_ready;
            new_m = 1'b0;
            byte_m = 8'h00;
            if (raw_valid) begin
                run_len  = (run_len > 0 && b == last_bit) ? run_len + 1 : 1;
                last_bit = b;
                if (m_warm > 0) begin
                    m_warm--;
                end else begin
                    m_pair.push_back(b);
                    if (m_pair.size() == 2) begin
                        if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
                        m_pair.delete();
                        if (m_bits.size() == 8) begin
                            for (int k = 0; k < 8; k++) byte_m = byte_m * 2 + 8'(m_bits[k]);
                            new_m = 1'b1;
                            m_bits.delete();
                        end
                    end
                end
            end
            if (pop_m) void'(m_fifo.pop_front());
            if (new_m) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(byte_m);
                else                       m_ovf = 1'b1;
            end
            tick();
        end
        raw_valid = 1'b0;
        check("rnd final level", fifo_level, m_fifo.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_byte_reader.md
Name: trng_byte_reader

Overview:
- Consumer end of the TRNG raw-bit stream: takes raw entropy bits from the ring-oscillator sampler and discards a warm-up window.
- Applies von Neumann debiasing and packs the surviving bits MSB-first into bytes.
- Buffers the bytes in a small FIFO and hands them to the host readout logic over a valid/ready handshake.
- Runs a repetition-count health test on the raw stream and latches a sticky failure.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, 2..16)
- WARMUP, 64, raw samples discarded after reset or en rising
- RCT_CUTOFF, 32, consecutive identical raw bits that trip the health test (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable
- raw_bit  in  1  raw TRNG sample
- raw_valid  in  1  raw_bit qualifier, one sample per cycle max
- byte_data  out  8  FIFO head byte
- byte_valid  out  1  FIFO non-empty and not failed
- byte_ready  in  1  consumer accepts byte_data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes held
- overflow  out  1  sticky: a byte was dropped while FIFO full
- health_fail  out  1  sticky: repetition-count test tripped

Behaviour:
- Reset: all outputs 0, FSM=WARMUP, all counters, pair and pack registers cleared, FIFO empty.
- FSM states: WARMUP, RUN, FAIL.
  - WARMUP -> RUN after WARMUP raw_valid samples with en=1. Samples taken in WARMUP feed neither the debiaser nor the RCT.
  - RUN -> FAIL when the RCT count reaches RCT_CUTOFF.
  - FAIL is left only by rst.
- en=0 (WARMUP or RUN):
  - warm-up counter, pair register, pack register/bit count and RCT count are cleared; FSM returns to WARMUP.
  - FIFO contents are kept and remain drainable.
  - en has no effect in FAIL.
- Debias (RUN, raw_valid=1):
  - The first sample of a pair is stored. The second sample closes the pair.
  - 10 emits 1, 01 emits 0, 00 and 11 emit nothing. The pair register is then emptied.
- Pack:
  - Each emitted bit shifts in at the LSB, giving {b0..b7} MSB-first.
  - On the 8th bit, the full byte is pushed to the FIFO in the same clock edge and the bit count wraps to 0.
  - If the FIFO was empty, byte_valid rises the cycle after the raw_valid that closed the 8th pair.
- FIFO:
  - Pop when byte_valid && byte_ready.
  - byte_data and byte_valid hold stable while byte_valid && !byte_ready.
  - Push while full with no pop: byte dropped, overflow set (sticky), fifo_level stays FIFO_DEPTH.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
  - Push and pop in the same cycle while level=1: new byte becomes head next cycle, byte_valid stays 1.
- RCT (RUN only):
  - count = 1 on the first post-warm-up sample.
  - Increment when raw_bit equals the previous sample; otherwise reset count to 1.
  - When count reaches RCT_CUTOFF: health_fail=1 on the next cycle, FSM=FAIL.
- FAIL: no pushes, FIFO flushed (fifo_level=0), byte_valid forced 0; raw_valid ignored.
- rst asserted mid-operation: immediate return to reset values regardless of state. FIFO contents, overflow and health_fail are lost.

Decomposition:
- Package trng_pkg:
  - FSM state enum (WARMUP/RUN/FAIL)
  - default parameter constants
  - level-width function
- Sub-module trng_byte_fifo: synchronous FIFO with push/pop/flush and level output.
- FSM, debiaser, packer and RCT live in trng_byte_reader.

Test Plan:
- Basic byte: reset, en=1, feed 64 warm-up samples, then pairs 10,01,10,10,01,01,10,01 with byte_ready=1 -> one byte 0xB2; byte_valid high exactly 1 cycle; fifo_level returns to 0.
- Discard pairs: after warm-up, feed 00,10,11,10,00,10,11,10,10,10,10,10 -> byte 0xFF, the 4 equal pairs produce nothing. Separately, 8 pairs of 01 -> 0x00.
- Overflow and backpressure: byte_ready=0, generate 5 bytes 0x01..0x05 -> fifo_level=4, overflow=1 after the 5th. Then byte_ready=1 drains 0x01..0x04 in order and byte_data stays stable while stalled.
- Health test: after warm-up, 31 consecutive 1s then a 0 -> health_fail=0. Then 32 consecutive 1s -> health_fail=1 and FIFO flushed. Further valid pairs produce no bytes until rst.
- en toggle: after 3 debiased bits, drop en for 1 cycle -> partial byte discarded and warm-up restarts (64 more samples are needed). A previously buffered byte is still readable while en=0.
- Reset mid-operation: 2 bytes buffered, overflow=1, then pulse rst -> all outputs 0 on the same edge and warm-up restarts.
